// File: rtl/rr_arbiter_4.sv
// ============================================================================
// rr_arbiter_4
// ----------------------------------------------------------------------------
// Four-requester round-robin arbiter. It produces a binary grant index and a
// grant enable that connect directly to a 2-to-4 decoder (gnt_idx_o to I,
// gnt_en_o to E). The arbiter owns the sequential policy: the fairness
// pointer, the grant hold, the release handshake and the hold timeout. The
// decoder that follows stays purely combinational.
//
// Every grant passes through IDLE for at least one cycle. The decoded
// one-hot bus therefore always drops to zero between two grants.
//
// Parameters
//   MAX_HOLD    : maximum consecutive cycles a single grant may be held
//                 (0 disables the timeout, legal range 0..255)
//
// Ports
//   clk_i       : rising-edge clock, the only clock
//   rst_i       : synchronous, active-high reset
//   req_i[3:0]  : level-sensitive request lines, bit n is requester n
//   release_i   : the current owner is done (sampled only while granting)
//   gnt_idx_o   : index of the granted requester
//   gnt_en_o    : grant valid
//   busy_o      : high while a grant is active (always equals gnt_en_o)
//   timeout_o   : one-cycle pulse when the hold limit revokes a grant
//
// All outputs come straight from flops. No combinational path runs from
// an input to an output.
// ============================================================================
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       release_i,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_en_o,
    output logic       busy_o,
    output logic       timeout_o
);

    // Two-state controller: waiting for a request, or holding a grant.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The hold counter starts at 0 in the first granted cycle. The grant is
    // therefore revoked on the edge where the counter reads MAX_HOLD-1,
    // which gives exactly MAX_HOLD cycles with the grant enable high.
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state_q,    state_d;
    logic [1:0] gnt_idx_q,  gnt_idx_d;
    logic       gnt_en_q,   gnt_en_d;
    logic       busy_q,     busy_d;
    logic       timeout_q,  timeout_d;
    logic [1:0] ptr_q,      ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] winnerIdx;
    logic       ownerReq;
    logic       holdLimitHit;

    // Round-robin search: the first set request bit, starting at the
    // priority pointer and wrapping modulo 4. The loop runs from the
    // farthest offset down to the nearest, so the closest candidate is
    // assigned last and wins.
    function automatic logic [1:0] pickWinner(input logic [3:0] r,
                                              input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] cand;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            cand = p + 2'(i);
            if (r[cand]) begin
                w = cand;
            end
        end
        return w;
    endfunction

    // Decode the request vector and the current holding conditions. During
    // a grant only the owner's request bit is relevant. The other request
    // lines are ignored until the arbiter returns to IDLE.
    always_comb begin
        winnerIdx    = pickWinner(req_i, ptr_q);
        ownerReq     = req_i[gnt_idx_q];
        holdLimitHit = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state and next-output logic. Every register defaults to holding
    // its value, except timeout, which defaults low so that it can only
    // pulse for a single cycle. A grant ends on the first of these, in
    // priority order: release, the owner dropping its request, the hold
    // limit. A release that coincides with the hold limit counts as a
    // release, so no timeout is reported in that case.
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_en_d   = gnt_en_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                gnt_en_d = 1'b0;
                if (req_i != 4'b0000) begin
                    state_d    = GRANT;
                    gnt_idx_d  = winnerIdx;
                    gnt_en_d   = 1'b1;
                    ptr_d      = winnerIdx + 2'd1;
                    hold_cnt_d = 8'd0;
                end
            end

            GRANT: begin
                if (release_i) begin
                    state_d  = IDLE;
                    gnt_en_d = 1'b0;
                end else if (!ownerReq) begin
                    state_d  = IDLE;
                    gnt_en_d = 1'b0;
                end else if (holdLimitHit) begin
                    state_d   = IDLE;
                    gnt_en_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d  = IDLE;
                gnt_en_d = 1'b0;
            end
        endcase

        busy_d = gnt_en_d;
    end

    // State and output registers. Reset overrides every other input,
    // including a grant in progress. gnt_idx also clears on reset, so the
    // decoder input returns to a known value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_idx_q  <= 2'd0;
            gnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_en_q   <= gnt_en_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Outputs are driven directly from flops.
    assign gnt_idx_o = gnt_idx_q;
    assign gnt_en_o  = gnt_en_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// ============================================================================
// tb_rr_arbiter_4
// ----------------------------------------------------------------------------
// Testbench for rr_arbiter_4 with MAX_HOLD = 8. A behavioural model tracks
// the arbiter: whether a grant is active, who owns it, how many cycles it
// has lasted and where the round-robin search starts next. Scenario tasks
// compare the DUT outputs against that model and against hand-derived
// constants. The last task is a long randomized run.
// ============================================================================
module tb_rr_arbiter_4;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [1:0] gnt_idx;
    logic       gnt_en;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    bit mBusy;
    int mIdx;
    int mPtr;
    int mHeld;
    bit mTo;

    rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .release_i (rel),
        .gnt_idx_o (gnt_idx),
        .gnt_en_o  (gnt_en),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock edge. It uses the inputs that were
    // stable before the edge. mHeld counts how many cycles the current
    // grant has already been visible.
    task automatic modelEdge();
        if (rst) begin
            mBusy = 0; mIdx = 0; mPtr = 0; mHeld = 0; mTo = 0;
        end else begin
            mTo = 0;
            if (!mBusy) begin
                if (req != 4'b0000) begin
                    for (int i = 0; i < 4; i++) begin
                        int c;
                        c = (mPtr + i) % 4;
                        if (req[c] && !mBusy) begin
                            mIdx  = c;
                            mBusy = 1;
                            mPtr  = (c + 1) % 4;
                            mHeld = 1;
                        end
                    end
                end
            end else begin
                if (rel) mBusy = 0;
                else if (!req[mIdx]) mBusy = 0;
                else if (MAXH != 0 && mHeld == MAXH) begin
                    mBusy = 0;
                    mTo   = 1;
                end else mHeld = mHeld + 1;
            end
        end
    endtask

    // One clock: edge, model update, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rl);
        req = r;
        rel = rl;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset for two cycles, then five idle cycles. Every output stays low.
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) rst = 1'b0;
            tick();
            checks++;
            if (gnt_en !== 1'b0 || gnt_idx !== 2'b00 || timeout !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle cyc=%0d: got en=%b idx=%b to=%b busy=%b expected all zero",
                         i, gnt_en, gnt_idx, timeout, busy);
            end
        end
    endtask

    // All four requesters active, with a release one cycle after each grant.
    // The decoded grant bus must rotate and return to zero in between.
    task automatic test_rotation();
        logic [3:0] expY [9];
        logic [3:0] y;
        expY = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        doReset();
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick();
            y = gnt_en ? (4'b0001 << gnt_idx) : 4'b0000;
            checks++;
            if (y !== expY[k] || gnt_en !== mBusy) begin
                failures++;
                $display("[TB] FAIL rotation step=%0d: got Y=%b expected Y=%b", k, y, expY[k]);
            end
            rel = gnt_en;
        end
        rel = 1'b0;
    endtask

    // After a grant to 2 the pointer sits at 3. With req=0011 the search
    // wraps to 0, and the grant after that goes to 1.
    task automatic test_wrap();
        int expIdx [3];
        expIdx = '{2, 0, 1};
        doReset();
        applyStimulus(4'b0100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (gnt_en !== 1'b1 || gnt_idx !== 2'(expIdx[k]) || gnt_idx !== 2'(mIdx)) begin
                failures++;
                $display("[TB] FAIL wrap grant=%0d: got en=%b idx=%0d expected en=1 idx=%0d",
                         k, gnt_en, gnt_idx, expIdx[k]);
            end
            applyStimulus(4'b0011, 1'b1);
            tick();
            checks++;
            if (gnt_en !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wrap_gap=%0d: got en=%b expected 0", k, gnt_en);
            end
            rel = 1'b0;
        end
    endtask

    // A single requester holds without releasing. The grant lasts exactly
    // MAX_HOLD cycles, timeout pulses once, and the requester is granted
    // again after one idle cycle.
    task automatic test_timeout();
        int cnt;
        bit idxOk;
        doReset();
        applyStimulus(4'b0100, 1'b0);
        tick();
        cnt = 0;
        idxOk = 1;
        while (gnt_en === 1'b1 && cnt < 3 * MAXH) begin
            if (gnt_idx !== 2'b10) idxOk = 0;
            cnt++;
            tick();
        end
        checks++;
        if (cnt != MAXH || !idxOk) begin
            failures++;
            $display("[TB] FAIL timeout_len: got %0d cycles idxOk=%0d expected %0d cycles idx=10",
                     cnt, idxOk, MAXH);
        end
        checks++;
        if (timeout !== 1'b1 || gnt_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_pulse: got to=%b en=%b expected to=1 en=0", timeout, gnt_en);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || gnt_en !== 1'b1 || gnt_idx !== 2'b10) begin
            failures++;
            $display("[TB] FAIL timeout_regrant: got to=%b en=%b idx=%b expected to=0 en=1 idx=10",
                     timeout, gnt_en, gnt_idx);
        end
    endtask

    // The owner drops its request mid-grant. Separately, a release arrives
    // on the same edge as the hold limit and wins, so no timeout is flagged.
    task automatic test_owner_drop();
        doReset();
        applyStimulus(4'b0010, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 2'b01) begin
            failures++;
            $display("[TB] FAIL drop_grant: got en=%b idx=%b expected en=1 idx=01", gnt_en, gnt_idx);
        end
        applyStimulus(4'b0000, 1'b0);
        tick();
        checks++;
        if (gnt_en !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 2'b01) begin
            failures++;
            $display("[TB] FAIL drop_end: got en=%b to=%b idx=%b expected en=0 to=0 idx=01",
                     gnt_en, timeout, gnt_idx);
        end

        doReset();
        applyStimulus(4'b0100, 1'b0);
        tick();
        for (int i = 0; i < MAXH - 1; i++) tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        checks++;
        if (gnt_en !== 1'b0 || timeout !== 1'b0 || mTo !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_vs_timeout: got en=%b to=%b expected en=0 to=0", gnt_en, timeout);
        end
    endtask

    // Reset during a grant to 3 clears everything. With req=1001 afterwards
    // the grant goes to 0, because the pointer has returned to 0.
    task automatic test_reset_mid();
        doReset();
        applyStimulus(4'b1000, 1'b0);
        tick();
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 2'b11) begin
            failures++;
            $display("[TB] FAIL midrst_setup: got en=%b idx=%b expected en=1 idx=11", gnt_en, gnt_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (gnt_en !== 1'b0 || gnt_idx !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_clear: got en=%b idx=%b busy=%b expected 0 00 0", gnt_en, gnt_idx, busy);
        end
        applyStimulus(4'b1001, 1'b0);
        tick();
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 2'b00) begin
            failures++;
            $display("[TB] FAIL midrst_regrant: got en=%b idx=%b expected en=1 idx=00", gnt_en, gnt_idx);
        end
    endtask

    // Long random run. Requests change often, release is occasional and
    // reset is rare. Every output is checked against the model each cycle.
    task automatic test_random();
        int bad;
        bad = 0;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rel = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (gnt_en !== mBusy || busy !== mBusy || timeout !== mTo || gnt_idx !== 2'(mIdx)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("[TB] FAIL random cyc=%0d: got en=%b busy=%b to=%b idx=%0d expected en=%0d to=%0d idx=%0d",
                             i, gnt_en, busy, timeout, gnt_idx, mBusy, mTo, mIdx);
            end
        end
        rst = 1'b0;
    endtask

    // Run the scenarios in sequence, then print the summary.
    initial begin
        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;
        mBusy = 0; mIdx = 0; mPtr = 0; mHeld = 0; mTo = 0;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_owner_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that produces a binary grant index plus a grant enable, which feed `decoder_2x4` directly (`gnt_idx` to `I`, `gnt_en` to `E`). The decoder turns them into a one-hot grant bus. This block owns the sequential policy: fairness pointer, grant hold, release handshake and hold timeout. The decoder stays purely combinational.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held. 0 disables the timeout. Legal range 0..255.
- `clk` input 1: rising-edge clock, the only clock.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request lines. Bit n is requester n. Level-sensitive.
- `release` input 1: the current owner is done. Sampled only in GRANT.
- `gnt_idx` output 2: index of the granted requester, to `decoder_2x4.I`.
- `gnt_en` output 1: grant valid, to `decoder_2x4.E`.
- `busy` output 1: high while in GRANT. Equal to `gnt_en`.
- `timeout` output 1: single-cycle pulse when a grant is revoked by the hold limit.

## Operation
- **State machine**: two states, IDLE and GRANT. All outputs are registered.
- **Internal state**: 2-bit priority pointer `ptr`; 8-bit hold counter `hold_cnt`.
- **Reset** (rst=1 at an edge), taking effect after that edge:
  - state=IDLE, gnt_idx=0, gnt_en=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
  - Reset overrides every other input, including mid-grant.
- **IDLE**:
  - req==0: stay in IDLE, outputs unchanged, gnt_en=0.
  - req!=0: pick the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that edge: gnt_idx ← winner, gnt_en ← 1, state ← GRANT, ptr ← winner+1 (mod 4, so 3 wraps to 0), hold_cnt ← 0.
- **GRANT** ends on the first of these, checked in this priority order:
  1. release=1.
  2. req[gnt_idx]=0 (the owner dropped its request).
  3. MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1. Here timeout ← 1 for exactly one cycle.
- **Ending a grant**: state ← IDLE, gnt_en ← 0. gnt_idx holds its last value.
- **Staying in GRANT**: otherwise hold_cnt ← hold_cnt+1. gnt_idx and gnt_en are stable.
- **Simultaneous events**: release and timeout in the same cycle count as a release, so timeout stays 0. Changes on other req bits during GRANT are ignored.
- **Fairness**: every grant passes through IDLE for at least one cycle, so gnt_en drops between consecutive grants, even to a different requester. The decoder output therefore never switches between two one-hot values without passing through zero.
- **Non-owner release**: release has no effect in IDLE.

## Timing
- **Grant latency**: req sampled at edge k means gnt_en=1 and gnt_idx valid after edge k, visible during cycle k+1.
- **Release latency**: release sampled at edge k means gnt_en=0 after edge k. The earliest next grant is after edge k+1.
- **Maximum grant length**: MAX_HOLD cycles of gnt_en=1. timeout is high in the first cycle after gnt_en falls.
- **Back-to-back throughput**: at most one grant per 2 cycles (grant, then mandatory idle).
- **Combinational paths**: none from inputs to outputs.

## Test plan
- **Reset and idle**: rst=1 for 2 cycles, then req=0000 for 5 cycles.
  - Expect gnt_en=0, gnt_idx=00, timeout=0 throughout.
- **Round-robin rotation**: hold req=1111, pulse release 1 cycle after each grant.
  - Expect gnt_idx sequence 0,1,2,3,0 with gnt_en low one cycle between grants.
  - Decoder Y sequence 0001,0000,0010,0000,0100,...
- **Pointer skip and wrap**: after a grant to 2, set req=0011.
  - Expect the next grant to be 0 (ptr=3 wraps to 0), then 1 on the following grant.
- **Timeout**: MAX_HOLD=8, req=0100, release=0.
  - Expect gnt_en high exactly 8 cycles with gnt_idx=10, then timeout=1 for 1 cycle.
  - Expect a regrant to 2 after one idle cycle.
- **Owner drop and simultaneity**:
  - Owner 1 drops req mid-grant: expect gnt_en low next cycle, timeout=0.
  - release asserted on the timeout cycle: expect timeout=0.
- **Reset mid-grant**: rst=1 while gnt_en=1, gnt_idx=3.
  - Expect gnt_en=0 and gnt_idx=00 next cycle.
  - After reset with req=1001, expect grant to 0 (ptr reset to 0).
